// File: rtl/hps_reset_sequencer_if.sv
// Signal bundle between the HPS reset sequencer and its requester/HPS side.
// The slave modport is the sequencer's view of the bundle; the master modport is the environment's view.
interface hps_reset_sequencer_if;
  logic [2:0] req;
  logic       h2f_reset_n;
  logic       cold_req_n;
  logic       warm_req_n;
  logic       debug_req_n;
  logic       busy;
  logic [2:0] grant;
  logic       timeout;

  modport master (
    output req, h2f_reset_n,
    input  cold_req_n, warm_req_n, debug_req_n, busy, grant, timeout
  );

  modport slave (
    input  req, h2f_reset_n,
    output cold_req_n, warm_req_n, debug_req_n, busy, grant, timeout
  );
endinterface

// File: rtl/hps_reset_sequencer.sv
// Turns rising edges on cold/warm/debug requests into fixed-length active-low
// HPS reset pulses, then tracks the fabric reset handshake before a holdoff gap.
module hps_reset_sequencer #(
  parameter int unsigned COLD_PULSE  = 6,
  parameter int unsigned WARM_PULSE  = 2,
  parameter int unsigned DEBUG_PULSE = 32,
  parameter int unsigned HOLDOFF     = 16,
  parameter int unsigned TIMEOUT     = 1000000
) (
  input logic              clk,
  input logic              rst,
  hps_reset_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_PULSE        = 3'd1;
  localparam logic [2:0] S_WAIT_ASSERT  = 3'd2;
  localparam logic [2:0] S_WAIT_RELEASE = 3'd3;
  localparam logic [2:0] S_HOLDOFF      = 3'd4;

  localparam logic [23:0] WAIT_LOAD = 24'(TIMEOUT);
  localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF);

  logic [2:0]  state;
  logic [2:0]  req_q;
  logic [2:0]  armed;
  logic [2:0]  pending;
  logic [2:0]  rise;
  logic [2:0]  pick;
  logic [2:0]  clr;
  logic [7:0]  pick_len;
  logic [2:0]  grant_q;
  logic [7:0]  pulse_cnt;
  logic [23:0] wait_cnt;
  logic [15:0] hold_cnt;
  logic        cold_n;
  logic        warm_n;
  logic        debug_n;
  logic        timeout_q;

  // A bit only counts as an edge once it has been sampled low since reset,
  // so a request held high across reset release stays silent.
  assign rise = bus.req & ~req_q & armed;

  always_comb begin
    pick     = 3'b000;
    pick_len = 8'd0;
    if (pending[0]) begin
      pick     = 3'b001;
      pick_len = 8'(COLD_PULSE);
    end else if (pending[1]) begin
      pick     = 3'b010;
      pick_len = 8'(WARM_PULSE);
    end else if (pending[2]) begin
      pick     = 3'b100;
      pick_len = 8'(DEBUG_PULSE);
    end
  end

  always_comb begin
    clr = 3'b000;
    if (state == S_IDLE) begin
      clr = pick[0] ? 3'b111 : pick;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= 3'b000;
      armed   <= 3'b000;
      pending <= 3'b000;
    end else begin
      req_q   <= bus.req;
      armed   <= armed | ~bus.req;
      pending <= (pending & ~clr) | rise;
    end
  end

  // Every down-counter exits on a count of one, so each state lasts exactly its load value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      grant_q   <= 3'b000;
      pulse_cnt <= 8'd0;
      wait_cnt  <= 24'd0;
      hold_cnt  <= 16'd0;
      cold_n    <= 1'b1;
      warm_n    <= 1'b1;
      debug_n   <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick != 3'b000) begin
            state     <= S_PULSE;
            grant_q   <= pick;
            pulse_cnt <= pick_len;
            cold_n    <= ~pick[0];
            warm_n    <= ~pick[1];
            debug_n   <= ~pick[2];
          end
        end
        S_PULSE: begin
          if (pulse_cnt <= 8'd1) begin
            pulse_cnt <= 8'd0;
            cold_n    <= 1'b1;
            warm_n    <= 1'b1;
            debug_n   <= 1'b1;
            if (grant_q[2]) begin
              state    <= S_HOLDOFF;
              hold_cnt <= HOLD_LOAD;
            end else begin
              state    <= S_WAIT_ASSERT;
              wait_cnt <= WAIT_LOAD;
            end
          end else begin
            pulse_cnt <= pulse_cnt - 8'd1;
          end
        end
        S_WAIT_ASSERT: begin
          if (!bus.h2f_reset_n) begin
            state    <= S_WAIT_RELEASE;
            wait_cnt <= WAIT_LOAD;
          end else if (wait_cnt <= 24'd1) begin
            wait_cnt  <= 24'd0;
            timeout_q <= 1'b1;
            state     <= S_HOLDOFF;
            hold_cnt  <= HOLD_LOAD;
          end else begin
            wait_cnt <= wait_cnt - 24'd1;
          end
        end
        S_WAIT_RELEASE: begin
          if (bus.h2f_reset_n) begin
            wait_cnt <= 24'd0;
            state    <= S_HOLDOFF;
            hold_cnt <= HOLD_LOAD;
          end else if (wait_cnt <= 24'd1) begin
            wait_cnt  <= 24'd0;
            timeout_q <= 1'b1;
            state     <= S_HOLDOFF;
            hold_cnt  <= HOLD_LOAD;
          end else begin
            wait_cnt <= wait_cnt - 24'd1;
          end
        end
        S_HOLDOFF: begin
          if (hold_cnt <= 16'd1) begin
            hold_cnt <= 16'd0;
            state    <= S_IDLE;
            grant_q  <= 3'b000;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          grant_q <= 3'b000;
          cold_n  <= 1'b1;
          warm_n  <= 1'b1;
          debug_n <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cold_req_n  = cold_n;
  assign bus.warm_req_n  = warm_n;
  assign bus.debug_req_n = debug_n;
  assign bus.busy        = (state != S_IDLE);
  assign bus.grant       = grant_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Bench for hps_reset_sequencer: a deadline-based reference model queues expected
// pulses, and a negedge monitor matches observed pulses and status against it.
module tb_hps_reset_sequencer;

  localparam int COLD_P  = 6;
  localparam int WARM_P  = 2;
  localparam int DEBUG_P = 32;
  localparam int HOLD_P  = 16;
  localparam int TMO_P   = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hps_auto = 1'b0;
  logic h2f_auto = 1'b1;
  logic h2f_manual = 1'b1;

  hps_reset_sequencer_if bus();

  hps_reset_sequencer #(
    .COLD_PULSE (COLD_P),
    .WARM_PULSE (WARM_P),
    .DEBUG_PULSE(DEBUG_P),
    .HOLDOFF    (HOLD_P),
    .TIMEOUT    (TMO_P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.h2f_reset_n = hps_auto ? h2f_auto : h2f_manual;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int kind;
    int start;
    int len;
  } pulse_t;

  typedef enum {M_IDLE, M_PULSE, M_WA, M_WR, M_HOLD} mphase_t;

  pulse_t    exp_q[$];
  mphase_t   m_phase = M_IDLE;
  int        cyc = 0;
  int        m_kind = 0;
  int        m_deadline = 0;
  int        pulse_len [3] = '{COLD_P, WARM_P, DEBUG_P};
  logic [2:0] m_pending = 3'b000;
  logic [2:0] m_prev = 3'b000;
  logic [2:0] m_armed = 3'b000;
  logic [2:0] m_rise;
  logic [2:0] m_clear;
  logic [2:0] exp_grant = 3'b000;
  logic       exp_timeout = 1'b0;
  pulse_t     m_new;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0d required %0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Reference model: each phase ends at an absolute cycle deadline derived from the pulse/holdoff/timeout lengths.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase     = M_IDLE;
      m_pending   = 3'b000;
      m_prev      = 3'b000;
      m_armed     = 3'b000;
      exp_grant   = 3'b000;
      exp_timeout = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      m_rise  = bus.req & ~m_prev & m_armed;
      m_clear = 3'b000;
      case (m_phase)
        M_IDLE: if (m_pending != 3'b000) begin
          m_kind     = m_pending[0] ? 0 : (m_pending[1] ? 1 : 2);
          exp_grant  = 3'b001 << m_kind;
          m_clear    = (m_kind == 0) ? 3'b111 : exp_grant;
          m_deadline = cyc + pulse_len[m_kind];
          m_new.kind  = m_kind;
          m_new.start = cyc;
          m_new.len   = pulse_len[m_kind];
          exp_q.push_back(m_new);
          m_phase = M_PULSE;
        end
        M_PULSE: if (cyc == m_deadline) begin
          if (m_kind == 2) begin
            m_phase = M_HOLD;
            m_deadline = cyc + HOLD_P;
          end else begin
            m_phase = M_WA;
            m_deadline = cyc + TMO_P;
          end
        end
        M_WA: if (!bus.h2f_reset_n) begin
          m_phase = M_WR;
          m_deadline = cyc + TMO_P;
        end else if (cyc == m_deadline) begin
          exp_timeout = 1'b1;
          m_phase = M_HOLD;
          m_deadline = cyc + HOLD_P;
        end
        M_WR: if (bus.h2f_reset_n) begin
          m_phase = M_HOLD;
          m_deadline = cyc + HOLD_P;
        end else if (cyc == m_deadline) begin
          exp_timeout = 1'b1;
          m_phase = M_HOLD;
          m_deadline = cyc + HOLD_P;
        end
        M_HOLD: if (cyc == m_deadline) begin
          m_phase = M_IDLE;
          exp_grant = 3'b000;
        end
        default: m_phase = M_IDLE;
      endcase
      m_pending = (m_pending & ~m_clear) | m_rise;
      m_armed   = m_armed | ~bus.req;
      m_prev    = bus.req;
    end
  end

  logic [2:0] low_active = 3'b000;
  int         low_start [3] = '{0, 0, 0};
  logic [2:0] req_n_vec;
  pulse_t     got;

  // Monitor: a completed low pulse is popped against the queue; status outputs are compared every cycle.
  always @(negedge clk) begin
    req_n_vec = {bus.debug_req_n, bus.warm_req_n, bus.cold_req_n};
    if (rst) begin
      low_active = 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!req_n_vec[i] && !low_active[i]) begin
          low_active[i] = 1'b1;
          low_start[i]  = cyc;
        end else if (req_n_vec[i] && low_active[i]) begin
          low_active[i] = 1'b0;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_pulse_kind", i, 99);
          end else begin
            got = exp_q.pop_front();
            checkOutput("pulse_kind", i, got.kind);
            checkOutput("pulse_start", low_start[i], got.start);
            checkOutput("pulse_len", cyc - low_start[i], got.len);
          end
        end
      end
    end
    checkOutput("single_low", ($countones(~req_n_vec) <= 1), 1);
    checkOutput("busy", bus.busy, (m_phase != M_IDLE));
    checkOutput("grant", bus.grant, exp_grant);
    checkOutput("timeout", bus.timeout, exp_timeout);
  end

  logic hps_arm = 1'b0;
  int   hps_delay = 0;
  int   hps_low = 0;

  // HPS stand-in: after a cold/warm pulse, drop h2f_reset_n for a random time, sometimes never or too long.
  always @(negedge clk) begin
    if (!bus.cold_req_n || !bus.warm_req_n) begin
      if (!hps_arm) begin
        hps_arm   = 1'b1;
        hps_delay = $urandom_range(1, 8);
        case ($urandom_range(0, 7))
          0:       hps_low = 0;
          1:       hps_low = $urandom_range(101, 130);
          default: hps_low = $urandom_range(1, 12);
        endcase
        if (hps_low == 0) hps_delay = $urandom_range(120, 140);
      end
    end else if (hps_arm) begin
      if (hps_delay > 0) begin
        hps_delay--;
      end else if (hps_low > 0) begin
        h2f_auto = 1'b0;
        hps_low--;
      end else begin
        h2f_auto = 1'b1;
        hps_arm  = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] bits);
    @(negedge clk);
    bus.req = bus.req | bits;
    @(negedge clk);
    bus.req = bus.req & ~bits;
  endtask

  task automatic waitReqN(input int idx, input logic level, input int budget);
    int k = 0;
    logic [2:0] v;
    v = {bus.debug_req_n, bus.warm_req_n, bus.cold_req_n};
    while (v[idx] !== level && k < budget) begin
      @(negedge clk);
      k++;
      v = {bus.debug_req_n, bus.warm_req_n, bus.cold_req_n};
    end
    checkOutput("req_n_wait", v[idx], level);
  endtask

  task automatic waitIdle(input int budget);
    int quiet = 0;
    int k = 0;
    while (quiet < 2 && k < budget) begin
      @(negedge clk);
      k++;
      quiet = bus.busy ? 0 : quiet + 1;
    end
    checkOutput("idle_wait", (quiet >= 2), 1);
  endtask

  initial begin
    bus.req = 3'b000;
    repeat (3) @(negedge clk);
    checkOutput("rst_cold_req_n", bus.cold_req_n, 1);
    checkOutput("rst_warm_req_n", bus.warm_req_n, 1);
    checkOutput("rst_debug_req_n", bus.debug_req_n, 1);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_grant", bus.grant, 0);
    checkOutput("rst_timeout", bus.timeout, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Warm with a well-behaved HPS handshake.
    applyStimulus(3'b010);
    waitReqN(1, 1'b0, 20);
    waitReqN(1, 1'b1, 20);
    repeat (3) @(negedge clk);
    h2f_manual = 1'b0;
    repeat (10) @(negedge clk);
    h2f_manual = 1'b1;
    waitIdle(200);

    // Simultaneous edges: cold wins and swallows the others.
    applyStimulus(3'b111);
    waitReqN(0, 1'b0, 20);
    checkOutput("grant_cold", bus.grant, 3'b001);
    waitReqN(0, 1'b1, 20);
    repeat (3) @(negedge clk);
    h2f_manual = 1'b0;
    repeat (4) @(negedge clk);
    h2f_manual = 1'b1;
    waitIdle(200);

    // Debug edge arrives while warm waits for fabric release.
    applyStimulus(3'b010);
    waitReqN(1, 1'b0, 20);
    waitReqN(1, 1'b1, 20);
    repeat (2) @(negedge clk);
    h2f_manual = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(3'b100);
    repeat (5) @(negedge clk);
    h2f_manual = 1'b1;
    waitIdle(300);

    // Cold with no fabric response: wait-assert times out and the flag sticks.
    applyStimulus(3'b001);
    waitIdle(400);
    checkOutput("timeout_sticky", bus.timeout, 1);
    repeat (5) @(negedge clk);
    checkOutput("timeout_still_set", bus.timeout, 1);

    // Reset in the third cycle of a cold pulse, with req held high through release.
    @(negedge clk);
    bus.req[0] = 1'b1;
    waitReqN(0, 1'b0, 20);
    repeat (2) @(negedge clk);
    checkOutput("cold_low_before_rst", bus.cold_req_n, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_cold_release", bus.cold_req_n, 1);
    checkOutput("async_busy", bus.busy, 0);
    checkOutput("async_timeout_clear", bus.timeout, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("held_req_no_pulse", bus.busy, 0);
    bus.req = 3'b000;
    repeat (3) @(negedge clk);

    // Random request toggling with a randomized HPS stand-in.
    hps_auto = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 24) == 0) begin
        int b;
        b = $urandom_range(0, 2);
        bus.req[b] = ~bus.req[b];
      end
    end
    bus.req = 3'b000;
    waitIdle(3000);
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("no_pulse_open", low_active, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hps_reset_sequencer.md
HPS_RESET_SEQUENCER -- requirements
Module: hps_reset_sequencer

Interface
REQ-001 The module SHALL have parameter COLD_PULSE, default 6, giving the cold request pulse length in clk cycles (legal range 1..255).
REQ-002 The module SHALL have parameter WARM_PULSE, default 2, giving the warm request pulse length in clk cycles (legal range 1..255).
REQ-003 The module SHALL have parameter DEBUG_PULSE, default 32, giving the debug request pulse length in clk cycles (legal range 1..255).
REQ-004 The module SHALL have parameter HOLDOFF, default 16, giving the minimum idle cycles between sequences (legal range 1..65535).
REQ-005 The module SHALL have parameter TIMEOUT, default 1000000, giving the maximum cycles spent in each wait state (legal range 1..2^24-1).
REQ-006 The module SHALL run on one clock and use an asynchronous, active-high reset: clk input 1 is the single clock, and all flops use its rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 req  input  3  level requests: [0]=cold, [1]=warm, [2]=debug; synchronous to clk.
REQ-009 h2f_reset_n  input  1  HPS-to-fabric reset status, low = fabric held in reset by HPS; synchronous to clk.
REQ-010 cold_req_n  output  1  active-low cold reset request to HPS.
REQ-011 warm_req_n  output  1  active-low warm reset request to HPS.
REQ-012 debug_req_n  output  1  active-low debug reset request to HPS.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 grant  output  3  one-hot copy of the request being serviced; 0 in IDLE.
REQ-015 timeout  output  1  sticky flag, set when any wait state expires.

Function
REQ-016 The module SHALL register req into req_q each cycle, and SHALL treat req & ~req_q as the rising-edge event for each bit.
REQ-017 A rising edge on bit i SHALL set pending[i] at that clock edge, and SHALL leave pending[i] set until it is granted.
REQ-018 Held levels SHALL NOT create new pending bits; only another 0->1 transition re-arms a bit.
REQ-019 The FSM SHALL have states IDLE, PULSE, WAIT_ASSERT, WAIT_RELEASE and HOLDOFF.
REQ-020 In IDLE with any pending bit set, the FSM SHALL grant by fixed priority cold > warm > debug and SHALL enter PULSE on the next edge.
REQ-021 On grant, the FSM SHALL load the pulse counter with the matching *_PULSE value and clear that pending bit; a cold grant SHALL also clear pending warm and debug.
REQ-022 In PULSE, the granted *_req_n output SHALL be 0 for exactly its *_PULSE cycles and 1 otherwise; at most one *_req_n SHALL be low at any time.
REQ-023 Latency from the req rising edge sampled at clock edge k SHALL be: pending at edge k, PULSE at edge k+1, *_req_n low from edge k+1 (registered outputs).
REQ-024 At the end of PULSE, cold and warm SHALL go to WAIT_ASSERT and debug SHALL go directly to HOLDOFF, because debug reset does not reset the fabric.
REQ-025 WAIT_ASSERT SHALL exit to WAIT_RELEASE when h2f_reset_n==0.
REQ-026 WAIT_RELEASE SHALL exit to HOLDOFF when h2f_reset_n==1.
REQ-027 Each wait state SHALL load a 24-bit counter with TIMEOUT on entry; on reaching 0 it SHALL set timeout and go to HOLDOFF.
REQ-028 HOLDOFF SHALL last exactly HOLDOFF cycles and then return to IDLE, with grant=0.
REQ-029 Edges arriving during any non-IDLE state SHALL set pending normally and SHALL be serviced after HOLDOFF.
REQ-030 Simultaneous edges SHALL set every affected pending bit in the same cycle, and priority SHALL then apply.
REQ-031 The timeout flag SHALL clear only on rst.
REQ-032 Counters SHALL saturate at 0 and SHALL never wrap.

Reset
REQ-033 While rst=1, the module SHALL hold cold_req_n=1, warm_req_n=1, debug_req_n=1, busy=0, grant=0, timeout=0, pending=0, req_q=0, all counters=0 and state=IDLE.
REQ-034 An rst assertion mid-sequence SHALL immediately deassert all *_req_n outputs (to 1) and discard pending requests.
REQ-035 After rst deasserts, a req bit already high SHALL NOT count as an edge until it has been sampled low and then high.

Verification
REQ-036 Warm edge, with h2f_reset_n low 3 cycles after the pulse and high 10 cycles later -> warm_req_n low for exactly 2 cycles starting 1 cycle after the edge sample; busy high through 16 HOLDOFF cycles; timeout=0.
REQ-037 Cold, warm and debug edges in the same cycle -> only cold_req_n pulses (6 cycles); warm and debug pending are dropped; grant=3'b001.
REQ-038 Debug edge during a warm WAIT_RELEASE -> debug_req_n low for 32 cycles, beginning 1 cycle after warm's HOLDOFF ends; no WAIT states entered for debug.
REQ-039 Cold edge with h2f_reset_n held at 1 and TIMEOUT=100 -> timeout=1 after 100 WAIT_ASSERT cycles, then HOLDOFF, then IDLE; timeout stays 1.
REQ-040 rst asserted on the 3rd cycle of a cold pulse -> cold_req_n=1 in the same cycle (async); req held high through rst release produces no pulse.
